// File: rtl/fft_output_reorder4_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the radix-4 FFT output reorder buffer.
//   FFT_N / LOG4_N / BEATS : default transform size, base-4 digit count and
//                            beats per frame (4 samples per beat)
//   SAMPLE_W               : default real/imag word width
//   cplx_t                 : complex sample {re, im}
//   rd_state_t             : read-side FSM states
//   drev4()                : base-4 digit reversal of an index
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N    = 16;
    localparam int LOG4_N   = 2;
    localparam int BEATS    = FFT_N / 4;
    localparam int SAMPLE_W = 32;

    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_t;

    // Reverse the lowest 'digits' base-4 digits of idx. The loop bound is a
    // constant so the function unrolls cleanly in synthesis.
    function automatic int unsigned drev4(input int unsigned idx, input int unsigned digits);
        int unsigned r;
        r = 0;
        for (int unsigned d = 0; d < 16; d++) begin
            if (d < digits) begin
                r = (r << 2) | ((idx >> (2 * d)) & 32'd3);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_output_reorder4_bank.sv
// -----------------------------------------------------------------------------
// reorder_bank
// One N-entry complex register file of the reorder ping-pong buffer.
//   clock    in  : write clock
//   we       in  : write enable for all four lanes
//   wr_addr  in  : per-lane write address (4 x log2(N))
//   wr_data  in  : per-lane write data {re, im} (4 x 2*WIDTH)
//   rd_row   in  : row index, selects entries 4*rd_row .. 4*rd_row+3
//   rd_data  out : the four entries of the selected row (combinational)
// Contents are not reset. The four lane addresses of one beat are always
// distinct, so the lanes never collide.
// -----------------------------------------------------------------------------
module reorder_bank
    import fft_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                      clock,
    input  logic                      we,
    input  logic [3:0][AW-1:0]        wr_addr,
    input  logic [3:0][2*WIDTH-1:0]   wr_data,
    input  logic [AW-3:0]             rd_row,
    output logic [3:0][2*WIDTH-1:0]   rd_data
);

    logic [2*WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int l = 0; l < 4; l++) begin
                mem[wr_addr[l]] <= wr_data[l];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd
            assign rd_data[gi] = mem[{rd_row, 2'(gi)}];
        end
    endgenerate

endmodule

// File: rtl/fft_output_reorder4.sv
// -----------------------------------------------------------------------------
// fft_output_reorder4
// Converts the base-4 digit-reversed output of the last radix-4 SDF stage into
// natural order, 4 complex samples per beat, through a two-bank ping-pong
// buffer so consecutive frames stream without a stall.
//   clock                       in  : system clock
//   reset                       in  : asynchronous, active-high
//   input_en                    in  : input beat valid
//   input_real_0..3/imag_0..3   in  : lane samples, digit-reversed order
//   output_en                   out : output beat valid
//   output_real_0..3/imag_0..3  out : lane samples, natural order (hold when idle)
//   overflow                    out : sticky, a beat arrived for a bank still full
// Optional (macro FFT_REORDER_FRAME_MARKERS_EN):
//   output_sof / output_eof     out : first / last output beat of each frame
// -----------------------------------------------------------------------------
module fft_output_reorder4
    import fft_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int Num_of_samples = FFT_N
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             input_en,
    input  logic [WIDTH-1:0] input_real_0,
    input  logic [WIDTH-1:0] input_real_1,
    input  logic [WIDTH-1:0] input_real_2,
    input  logic [WIDTH-1:0] input_real_3,
    input  logic [WIDTH-1:0] input_imag_0,
    input  logic [WIDTH-1:0] input_imag_1,
    input  logic [WIDTH-1:0] input_imag_2,
    input  logic [WIDTH-1:0] input_imag_3,
    output logic             output_en,
    output logic [WIDTH-1:0] output_real_0,
    output logic [WIDTH-1:0] output_real_1,
    output logic [WIDTH-1:0] output_real_2,
    output logic [WIDTH-1:0] output_real_3,
    output logic [WIDTH-1:0] output_imag_0,
    output logic [WIDTH-1:0] output_imag_1,
    output logic [WIDTH-1:0] output_imag_2,
    output logic [WIDTH-1:0] output_imag_3,
    output logic             overflow
`ifdef FFT_REORDER_FRAME_MARKERS_EN
    ,
    output logic             output_sof,
    output logic             output_eof
`endif
);

    localparam int N_DIGITS = $clog2(Num_of_samples) / 2;
    localparam int N_BEATS  = Num_of_samples / 4;
    localparam int AW       = $clog2(Num_of_samples);
    localparam int CW       = AW - 2;
    localparam int DW       = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N_BEATS - 1);

    logic [3:0][DW-1:0] wr_data;
    logic [3:0][AW-1:0] wr_addr;
    logic [3:0][DW-1:0] rd_data_0;
    logic [3:0][DW-1:0] rd_data_1;
    logic [3:0][DW-1:0] rd_data;

    logic [CW-1:0] wr_cnt_reg, wr_cnt_next;
    logic          wr_bank_reg, wr_bank_next;
    logic [1:0]    full_reg, full_next;
    logic [1:0]    set_vec, clr_vec;
    logic          accept, drop;

    rd_state_t     state_reg, state_next;
    logic [CW-1:0] rd_cnt_reg, rd_cnt_next;
    logic          rd_bank_reg, rd_bank_next;
    logic          drain_last;

    logic               output_en_reg;
    logic               overflow_reg;
    logic [3:0][DW-1:0] out_data_reg;

    assign wr_data[0] = {input_real_0, input_imag_0};
    assign wr_data[1] = {input_real_1, input_imag_1};
    assign wr_data[2] = {input_real_2, input_imag_2};
    assign wr_data[3] = {input_real_3, input_imag_3};

    // Arrival index of lane gi is 4*wr_cnt + gi; it lands at its digit-reversed
    // position so the bank ends up holding the frame in natural order.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_addr[gi] = AW'(drev4(32'({wr_cnt_reg, 2'(gi)}), N_DIGITS));
            assign rd_data[gi] = rd_bank_reg ? rd_data_1[gi] : rd_data_0[gi];
        end
    endgenerate

    reorder_bank #(
        .WIDTH (WIDTH),
        .DEPTH (Num_of_samples)
    ) u_bank_0 (
        .clock   (clock),
        .we      (accept && !wr_bank_reg),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_row  (rd_cnt_reg),
        .rd_data (rd_data_0)
    );

    reorder_bank #(
        .WIDTH (WIDTH),
        .DEPTH (Num_of_samples)
    ) u_bank_1 (
        .clock   (clock),
        .we      (accept && wr_bank_reg),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_row  (rd_cnt_reg),
        .rd_data (rd_data_1)
    );

    assign drain_last = (state_reg == RD_DRAIN) && (rd_cnt_reg == LAST_BEAT);

    // Write side. A bank whose last row is being read this cycle counts as
    // free: its old contents are captured into the output register on the same
    // edge the new beat is written, which keeps back-to-back frames gap-free.
    always_comb begin
        clr_vec      = 2'b00;
        set_vec      = 2'b00;
        wr_cnt_next  = wr_cnt_reg;
        wr_bank_next = wr_bank_reg;
        if (drain_last) begin
            clr_vec[rd_bank_reg] = 1'b1;
        end
        accept = input_en && !(full_reg[wr_bank_reg] && !clr_vec[wr_bank_reg]);
        drop   = input_en && !accept;
        if (accept) begin
            if (wr_cnt_reg == LAST_BEAT) begin
                set_vec[wr_bank_reg] = 1'b1;
                wr_bank_next         = !wr_bank_reg;
                wr_cnt_next          = '0;
            end else begin
                wr_cnt_next = wr_cnt_reg + CW'(1);
            end
        end
        // Set has priority over clear on the same bank.
        full_next = (full_reg & ~clr_vec) | set_vec;
    end

    // Read FSM next-state logic.
    always_comb begin
        state_next   = state_reg;
        rd_cnt_next  = rd_cnt_reg;
        rd_bank_next = rd_bank_reg;
        case (state_reg)
            RD_IDLE: begin
                if (full_reg[rd_bank_reg]) begin
                    state_next  = RD_DRAIN;
                    rd_cnt_next = '0;
                end
            end
            RD_DRAIN: begin
                rd_cnt_next = rd_cnt_reg + CW'(1);
                if (drain_last) begin
                    rd_bank_next = !rd_bank_reg;
                    rd_cnt_next  = '0;
                    if (!full_reg[!rd_bank_reg]) begin
                        state_next = RD_IDLE;
                    end
                end
            end
            default: state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= RD_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_cnt_reg  <= '0;
            rd_bank_reg <= 1'b0;
            wr_cnt_reg  <= '0;
            wr_bank_reg <= 1'b0;
            full_reg    <= 2'b00;
        end else begin
            rd_cnt_reg  <= rd_cnt_next;
            rd_bank_reg <= rd_bank_next;
            wr_cnt_reg  <= wr_cnt_next;
            wr_bank_reg <= wr_bank_next;
            full_reg    <= full_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            output_en_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            output_en_reg <= (state_reg == RD_DRAIN);
            overflow_reg  <= overflow_reg | drop;
            if (state_reg == RD_DRAIN) begin
                out_data_reg <= rd_data;
            end
        end
    end

    assign output_en     = output_en_reg;
    assign overflow      = overflow_reg;
    assign output_real_0 = out_data_reg[0][DW-1:WIDTH];
    assign output_real_1 = out_data_reg[1][DW-1:WIDTH];
    assign output_real_2 = out_data_reg[2][DW-1:WIDTH];
    assign output_real_3 = out_data_reg[3][DW-1:WIDTH];
    assign output_imag_0 = out_data_reg[0][WIDTH-1:0];
    assign output_imag_1 = out_data_reg[1][WIDTH-1:0];
    assign output_imag_2 = out_data_reg[2][WIDTH-1:0];
    assign output_imag_3 = out_data_reg[3][WIDTH-1:0];

`ifdef FFT_REORDER_FRAME_MARKERS_EN
    logic sof_reg;
    logic eof_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sof_reg <= 1'b0;
            eof_reg <= 1'b0;
        end else begin
            sof_reg <= (state_reg == RD_DRAIN) && (rd_cnt_reg == '0);
            eof_reg <= drain_last;
        end
    end

    assign output_sof = sof_reg;
    assign output_eof = eof_reg;
`else
    // Frame markers not built.
`endif

endmodule

// File: tb/tb_fft_output_reorder4.sv
// -----------------------------------------------------------------------------
// tb_fft_output_reorder4
// Directed self-checking bench for fft_output_reorder4 (N=16, WIDTH=32).
// Sample with arrival index a carries real=base+a, imag=-(base+a). Expected
// natural-order beats are queued when a frame is driven and popped as the DUT
// emits output beats. Frame marker checks are built when
// FFT_REORDER_FRAME_MARKERS_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_output_reorder4;
    import fft_pkg::*;

    localparam int W = 32;
    localparam int N = 16;

    typedef logic [3:0][31:0] beat_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         input_en = 1'b0;
    logic [W-1:0] input_real_0 = '0, input_real_1 = '0, input_real_2 = '0, input_real_3 = '0;
    logic [W-1:0] input_imag_0 = '0, input_imag_1 = '0, input_imag_2 = '0, input_imag_3 = '0;
    logic         output_en;
    logic [W-1:0] output_real_0, output_real_1, output_real_2, output_real_3;
    logic [W-1:0] output_imag_0, output_imag_1, output_imag_2, output_imag_3;
    logic         overflow;
`ifdef FFT_REORDER_FRAME_MARKERS_EN
    logic         output_sof;
    logic         output_eof;
`endif

    always #5 clock = ~clock;

    fft_output_reorder4 #(
        .WIDTH          (W),
        .Num_of_samples (N)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .input_en      (input_en),
        .input_real_0  (input_real_0),
        .input_real_1  (input_real_1),
        .input_real_2  (input_real_2),
        .input_real_3  (input_real_3),
        .input_imag_0  (input_imag_0),
        .input_imag_1  (input_imag_1),
        .input_imag_2  (input_imag_2),
        .input_imag_3  (input_imag_3),
        .output_en     (output_en),
        .output_real_0 (output_real_0),
        .output_real_1 (output_real_1),
        .output_real_2 (output_real_2),
        .output_real_3 (output_real_3),
        .output_imag_0 (output_imag_0),
        .output_imag_1 (output_imag_1),
        .output_imag_2 (output_imag_2),
        .output_imag_3 (output_imag_3),
        .overflow      (overflow)
`ifdef FFT_REORDER_FRAME_MARKERS_EN
        ,
        .output_sof    (output_sof),
        .output_eof    (output_eof)
`endif
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    cap_cyc = 0;
    int    rise_cyc = -1;
    int    run_len = 0;
    int    last_run = 0;
    int    out_idx = 0;
    logic  prev_en = 1'b0;
    beat_t exp_q[$];

    function automatic cplx_t lane_obs(input int l);
        case (l)
            0:       return '{re: output_real_0, im: output_imag_0};
            1:       return '{re: output_real_1, im: output_imag_1};
            2:       return '{re: output_real_2, im: output_imag_2};
            default: return '{re: output_real_3, im: output_imag_3};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample outputs on the falling edge and score any output beat.
    task automatic tick();
        beat_t e;
        cplx_t o;
        cplx_t x;
        @(negedge clock);
        cyc++;
        if (reset) begin
            prev_en = 1'b0;
            run_len = 0;
            out_idx = 0;
        end else begin
            if (output_en) begin
                if (!prev_en) rise_cyc = cyc;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat observed output_en=1 required no beat (none pending)");
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    for (int l = 0; l < 4; l++) begin
                        o = lane_obs(l);
                        x.re = e[l];
                        x.im = -e[l];
                        checks++;
                        assert (o === x) else begin
                            errors++;
                            $error("FAIL beat%0d_lane%0d observed=%h required=%h", out_idx, l, o, x);
                        end
                    end
                end
`ifdef FFT_REORDER_FRAME_MARKERS_EN
                chk("sof", 256'(output_sof), 256'(out_idx % 4 == 0));
                chk("eof", 256'(output_eof), 256'(out_idx % 4 == 3));
`endif
                out_idx++;
                run_len++;
            end else if (prev_en) begin
                last_run = run_len;
                run_len  = 0;
            end
            prev_en = output_en;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            input_en = 1'b0;
        end
    endtask

    // Drive beat k of the frame with base b (arrival indices 4k..4k+3).
    task automatic drive_beat(input int b, input int k);
        tick();
        input_en     = 1'b1;
        input_real_0 = 32'(b + 4 * k + 0);
        input_real_1 = 32'(b + 4 * k + 1);
        input_real_2 = 32'(b + 4 * k + 2);
        input_real_3 = 32'(b + 4 * k + 3);
        input_imag_0 = 32'(-(b + 4 * k + 0));
        input_imag_1 = 32'(-(b + 4 * k + 1));
        input_imag_2 = 32'(-(b + 4 * k + 2));
        input_imag_3 = 32'(-(b + 4 * k + 3));
        cap_cyc      = cyc + 1;
    endtask

    // Output beat r lane l is natural index 4r+l; its two base-4 digits are
    // (r, l), so it arrived as a = 4l + r.
    task automatic push_frame(input int b);
        beat_t e;
        for (int r = 0; r < 4; r++) begin
            for (int l = 0; l < 4; l++) e[l] = 32'(b + 4 * l + r);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int b, input bit gaps);
        push_frame(b);
        $display("frame base=%0d sent gaps=%0d", b, gaps);
        for (int k = 0; k < 4; k++) begin
            drive_beat(b, k);
            if (gaps) idle(int'($urandom_range(1, 3)));
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || prev_en) && n < 80) begin
            idle(1);
            n++;
        end
        chk({tag, "_drain_pending"}, 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        // Reset state
        idle(2);
        chk("rst_en", 256'(output_en), 256'(0));
        chk("rst_ovf", 256'(overflow), 256'(0));
        chk("rst_data", {output_real_0, output_real_1, output_real_2, output_real_3,
                         output_imag_0, output_imag_1, output_imag_2, output_imag_3}, 256'(0));
        reset = 1'b0;
        idle(2);

        // Test 1: one contiguous frame
        send_frame(0, 1'b0);
        idle(1);
        wait_drain("t1");
        chk("t1_latency", 256'(rise_cyc - cap_cyc), 256'(2));
        chk("t1_run", 256'(last_run), 256'(4));
        idle(3);
        chk("t1_hold", {output_real_3, output_imag_3}, {32'd15, -32'd15});

        // Test 2: three frames back-to-back
        send_frame(100, 1'b0);
        send_frame(200, 1'b0);
        send_frame(300, 1'b0);
        idle(1);
        wait_drain("t2");
        chk("t2_run", 256'(last_run), 256'(12));
        chk("t2_ovf", 256'(overflow), 256'(0));

        // Test 3: same frame as test 1 with idle gaps
        send_frame(0, 1'b1);
        wait_drain("t3");
        chk("t3_latency", 256'(rise_cyc - cap_cyc), 256'(2));
        chk("t3_run", 256'(last_run), 256'(4));

        // Test 4: reader held off, nine beats without gaps
        force dut.state_reg = RD_IDLE;
        push_frame(400);
        push_frame(500);
        for (int k = 0; k < 4; k++) drive_beat(400, k);
        for (int k = 0; k < 4; k++) drive_beat(500, k);
        drive_beat(900, 0);
        chk("t4_ovf_before", 256'(overflow), 256'(0));
        idle(1);
        chk("t4_ovf_drop", 256'(overflow), 256'(1));
        idle(3);
        release dut.state_reg;
        wait_drain("t4");
        chk("t4_run", 256'(last_run), 256'(8));
        send_frame(600, 1'b0);
        idle(1);
        wait_drain("t4_next");
        chk("t4_next_run", 256'(last_run), 256'(4));
        chk("t4_ovf_sticky", 256'(overflow), 256'(1));

        // Test 5: reset in the middle of a frame
        drive_beat(700, 0);
        drive_beat(700, 1);
        drive_beat(700, 2);
        tick();
        input_en = 1'b0;
        reset    = 1'b1;
        tick();
        chk("t5_rst_en", 256'(output_en), 256'(0));
        chk("t5_rst_ovf", 256'(overflow), 256'(0));
        chk("t5_rst_data", {output_real_0, output_real_1, output_real_2, output_real_3,
                            output_imag_0, output_imag_1, output_imag_2, output_imag_3}, 256'(0));
        tick();
        reset = 1'b0;
        idle(2);
        send_frame(800, 1'b0);
        idle(1);
        wait_drain("t5");
        chk("t5_latency", 256'(rise_cyc - cap_cyc), 256'(2));
        chk("t5_run", 256'(last_run), 256'(4));
        chk("t5_ovf", 256'(overflow), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
